cpu_bus_ctrl: RTL and testbench
===============================

Name: cpu_bus_ctrl

Overview:
Bus-cycle sequencer for the 68000 board. It decodes each CPU cycle into ROM, RAM or a device region and generates chip-enables and `_dtack`. It also runs the timed `_rd`/`wr` strobe handshake to the FT245 USB FIFO and drives serial-status bits onto D0. It replaces the board's always-asserted `_dtack`, adding a bus-error timeout so a stalled FIFO cannot hang the CPU.

Parameters:
- ROM_WS, 1: wait states (clk cycles) added before `_dtack` on ROM cycles.
- RAM_WS, 0: wait states added before `_dtack` on RAM cycles.
- RD_PULSE, 4: clk cycles `_rd` is held low before `_dtack`.
- WR_PULSE, 3: clk cycles `wr` is held high before `_dtack`.
- TIMEOUT, 255: clk cycles spent waiting for the FIFO flag before `_berr` asserts; 8-bit counter.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- addr  in  8  CPU A19..A12.
- _as  in  1  address strobe, active low, asynchronous to clk.
- _ds  in  1  data strobe, active low, asynchronous to clk.
- rw  in  1  1 = read, 0 = write.
- fc0, fc1  in  1 each  function codes; both high = interrupt acknowledge.
- _txe  in  1  FT245 transmit-empty flag, low = room to write.
- _rdf  in  1  FT245 receive flag, low = data available.
- d0_in  in  1  CPU D0, used for LED register writes.
- _cerom  out  1  ROM chip enable, active low.
- _ceram  out  1  RAM chip enable, active low.
- _oe  out  1  memory output enable, active low.
- _rd  out  1  FT245 read strobe, active low.
- wr  out  1  FT245 write strobe, active high.
- _dtack  out  1  data transfer acknowledge, active low.
- _berr  out  1  bus error, active low.
- d0_oe  out  1  drive D0 with `d0_out`.
- d0_out  out  1  serial-status bit returned on D0.
- status_led  out  1  LED register.

Behaviour:
- Synchronisation: `_as`, `_ds`, `_txe` and `_rdf` each pass through a 2-flop synchroniser. All decisions below use the synchronised copies.
- Reset: every output returns to its inactive value immediately, even mid-cycle.
  - `_cerom`, `_ceram`, `_oe`, `_rd`, `_dtack`, `_berr` = 1.
  - `wr`, `d0_oe`, `d0_out`, `status_led` = 0.
  - FSM = IDLE; counters = 0.
- Region decode, latched in DECODE:
  - iack: fc1 & fc0. No enables asserted, no `_dtack`; the cycle is left to `_vpa`.
  - dev: addr[19:15] = 01111. Sub-select on addr[14:13]:
    - 00 = serial read
    - 01 = serial write
    - 10 = status (addr[12]: 0 → `_rdf`, 1 → `_txe`)
    - 11 = LED
  - rom: addr[19] = 0 and not dev.
  - ram: addr[19] = 1.
- `_oe` = ~rw while in any non-IDLE state with a rom/ram region, else 1.
- FSM states and transitions:
  - IDLE: sync `_as` falling → DECODE.
  - DECODE (1 cycle):
    - rom/ram: assert `_cerom`/`_ceram`, load the wait counter with ROM_WS/RAM_WS → MEMWAIT.
    - serial read → RDWAIT.
    - serial write → WRWAIT.
    - status: `d0_oe` = 1 → ACK.
    - LED: wait for sync `_ds` low, latch `status_led` ← d0_in → ACK.
    - iack → HOLD.
  - MEMWAIT: counter == 0 → ACK; otherwise decrement each cycle.
  - RDWAIT: `_rdf` = 0 → RDSTB (`_rd` low, pulse counter loaded with RD_PULSE). Each cycle spent here increments the timeout count; at TIMEOUT → BERR.
  - WRWAIT: `_txe` = 0 and `_ds` = 0 → WRSTB (`wr` high, counter loaded with WR_PULSE). Timeout rule as RDWAIT.
  - RDSTB / WRSTB: counter reaches 0 → ACK. The strobe stays asserted through ACK until `_as` rises.
  - ACK: `_dtack` = 0. Sync `_as` high → IDLE, deasserting `_dtack`, strobes, enables and `d0_oe` on that same edge.
  - BERR: `_berr` = 0 until sync `_as` high → IDLE. `_dtack` is never asserted in this state.
  - HOLD: wait for sync `_as` high → IDLE.
- Abort: `_as` rising in any non-IDLE state forces a return to IDLE and drops all outputs, whether or not the cycle completed.
- Latency from sync `_as` low to `_dtack` low:
  - ROM: 2 + ROM_WS cycles.
  - RAM: 2 + RAM_WS cycles.
  - Serial read: 1 cycle + flag wait + RD_PULSE + 1.
  - Status / LED: 2 cycles.
- Invariants: `_rd` low and `wr` high are never both asserted. No back-to-back cycle starts without an IDLE cycle in between.

Decomposition:
- Package `cpu_bus_pkg`:
  - state enum;
  - region enum (R_NONE, R_ROM, R_RAM, R_SRD, R_SWR, R_STAT, R_LED, R_IACK);
  - DEV_BASE = 5'b01111;
  - sub-select codes.
- One sub-module, `sync2`: parameterised-width 2-flop synchroniser with asynchronous active-high reset.

Test Plan:
1. ROM read, addr = 0x05: `_cerom` low and `_oe` low; `_dtack` low exactly 3 cycles after sync `_as` low; `_as` high → all outputs released on the next edge.
2. Serial read with `_rdf` held high 10 cycles, then low: `_rd` low for 4 cycles, then `_dtack` low; `_berr` stays high.
3. Serial write with `_txe` stuck high: `_berr` low after 255 cycles; `wr` never rises; `_dtack` stays high.
4. LED write to 0x7E with d0_in = 1: `status_led` = 1 and `_dtack` 2 cycles after `_as`. A status read to 0x7D with `_txe` = 0 gives `d0_oe` = 1 and `d0_out` = 0.
5. Interrupt acknowledge, fc = 11: no enables and no `_dtack`. Reset asserted mid-RDSTB: `_rd` goes high asynchronously and FSM = IDLE.
6. `_as` dropped during WRWAIT: FSM returns to IDLE, no strobe pulse; the next cycle decodes correctly.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_bus_pkg
//  Brief    : Shared types and address-map constants for the 68000 bus-cycle
//             sequencer: FSM state encoding, decoded cycle regions and the
//             device-window sub-select codes.
//  Revision : 1.0  initial release
// ============================================================================
package cpu_bus_pkg;

  // Bus-cycle sequencer states
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMWAIT = 4'd2,
    S_RDWAIT  = 4'd3,
    S_WRWAIT  = 4'd4,
    S_RDSTB   = 4'd5,
    S_WRSTB   = 4'd6,
    S_ACK     = 4'd7,
    S_BERR    = 4'd8,
    S_HOLD    = 4'd9
  } state_t;

  // Region a CPU cycle decodes into
  typedef enum logic [2:0] {
    R_NONE = 3'd0,
    R_ROM  = 3'd1,
    R_RAM  = 3'd2,
    R_SRD  = 3'd3,
    R_SWR  = 3'd4,
    R_STAT = 3'd5,
    R_LED  = 3'd6,
    R_IACK = 3'd7
  } region_t;

  // A19..A15 pattern selecting the device window
  localparam logic [4:0] DEV_BASE = 5'b01111;

  // A14..A13 sub-select inside the device window
  localparam logic [1:0] SUB_SER_RD = 2'b00;
  localparam logic [1:0] SUB_SER_WR = 2'b01;
  localparam logic [1:0] SUB_STATUS = 2'b10;
  localparam logic [1:0] SUB_LED    = 2'b11;

  // Map A19..A12 plus function codes onto a cycle region.
  // The port carries A19..A12, so A19..A15 = a[7:3] and A14..A13 = a[2:1].
  // Interrupt acknowledge wins over any address decode.
  function automatic region_t decode_region(input logic [7:0] a,
                                            input logic       f1,
                                            input logic       f0);
    region_t r;
    r = R_NONE;
    if (f1 && f0) begin
      r = R_IACK;
    end else if (a[7:3] == DEV_BASE) begin
      case (a[2:1])
        SUB_SER_RD: r = R_SRD;
        SUB_SER_WR: r = R_SWR;
        SUB_STATUS: r = R_STAT;
        default:    r = R_LED;
      endcase
    end else if (!a[7]) begin
      r = R_ROM;
    end else begin
      r = R_RAM;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
//  Module   : sync2
//  Brief    : Parameterised-width two-flop synchroniser with asynchronous
//             active-high reset to a configurable idle value.
//  Revision : 1.0  initial release
// ============================================================================
module sync2 #(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two back-to-back flops; reset parks both at the idle value so no false
  // edge is seen when reset releases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/cpu_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_bus_ctrl
//  Brief    : 68000 bus-cycle sequencer. Decodes each cycle into ROM, RAM or
//             the device window, generates chip enables and _dtack, runs the
//             FT245 _rd/wr strobe handshake with a bus-error timeout, and
//             returns serial status on D0.
//  Revision : 1.0  initial release
// ============================================================================
module cpu_bus_ctrl
  import cpu_bus_pkg::*;
#(
  parameter int ROM_WS   = 1,
  parameter int RAM_WS   = 0,
  parameter int RD_PULSE = 4,
  parameter int WR_PULSE = 3,
  parameter int TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] addr,
  input  logic       _as,
  input  logic       _ds,
  input  logic       rw,
  input  logic       fc0,
  input  logic       fc1,
  input  logic       _txe,
  input  logic       _rdf,
  input  logic       d0_in,
  output logic       _cerom,
  output logic       _ceram,
  output logic       _oe,
  output logic       _rd,
  output logic       wr,
  output logic       _dtack,
  output logic       _berr,
  output logic       d0_oe,
  output logic       d0_out,
  output logic       status_led
);

  // Counter loads. Wait/pulse counters are loaded with length-1 so that the
  // state is occupied for exactly the configured number of cycles.
  localparam logic [7:0] c_ROM_LOAD = 8'(ROM_WS - 1);
  localparam logic [7:0] c_RAM_LOAD = 8'(RAM_WS - 1);
  localparam logic [7:0] c_RD_LOAD  = 8'(RD_PULSE - 1);
  localparam logic [7:0] c_WR_LOAD  = 8'(WR_PULSE - 1);
  localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT - 1);

  // --------------------------------------------------------------------------
  // Synchronised copies of the asynchronous strobes and FIFO flags
  // --------------------------------------------------------------------------
  logic [3:0] w_sync_in;
  logic [3:0] w_sync_out;
  logic       w_as_s;
  logic       w_ds_s;
  logic       w_txe_s;
  logic       w_rdf_s;

  assign w_sync_in = {_as, _ds, _txe, _rdf};

  // All four inputs are active low, so they idle (and reset) high
  sync2 #(
    .WIDTH     (4),
    .RESET_VAL (4'hF)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (w_sync_in),
    .q     (w_sync_out)
  );

  assign w_as_s  = w_sync_out[3];
  assign w_ds_s  = w_sync_out[2];
  assign w_txe_s = w_sync_out[1];
  assign w_rdf_s = w_sync_out[0];

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  state_t     r_state;
  state_t     w_state_next;
  region_t    r_region;
  region_t    w_region_next;
  logic       r_stat_sel;
  logic       w_stat_sel_next;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_next;
  logic [7:0] r_tmo;
  logic [7:0] w_tmo_next;
  logic       r_status_led;
  logic       w_led_next;

  // State, region latch, counters and LED register; reset is asynchronous
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_region     <= R_NONE;
      r_stat_sel   <= 1'b0;
      r_cnt        <= 8'd0;
      r_tmo        <= 8'd0;
      r_status_led <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_region     <= w_region_next;
      r_stat_sel   <= w_stat_sel_next;
      r_cnt        <= w_cnt_next;
      r_tmo        <= w_tmo_next;
      r_status_led <= w_led_next;
    end
  end

  // Next-state logic: a synchronised _as release in any active state ends
  // the cycle; otherwise each state advances on its own condition.
  always_comb begin
    w_state_next    = r_state;
    w_region_next   = r_region;
    w_stat_sel_next = r_stat_sel;
    w_cnt_next      = r_cnt;
    w_tmo_next      = r_tmo;
    w_led_next      = r_status_led;

    if (r_state != S_IDLE && w_as_s) begin
      // Normal completion from ACK/BERR/HOLD, or an abort from anywhere else
      w_state_next  = S_IDLE;
      w_region_next = R_NONE;
      w_cnt_next    = 8'd0;
      w_tmo_next    = 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_as_s) begin
            w_state_next    = S_DECODE;
            w_region_next   = decode_region(addr, fc1, fc0);
            w_stat_sel_next = addr[0];
          end
        end

        S_DECODE: begin
          case (r_region)
            R_ROM: begin
              if (ROM_WS == 0) begin
                w_state_next = S_ACK;
              end else begin
                w_cnt_next   = c_ROM_LOAD;
                w_state_next = S_MEMWAIT;
              end
            end
            R_RAM: begin
              if (RAM_WS == 0) begin
                w_state_next = S_ACK;
              end else begin
                w_cnt_next   = c_RAM_LOAD;
                w_state_next = S_MEMWAIT;
              end
            end
            R_SRD: begin
              w_tmo_next   = 8'd0;
              w_state_next = S_RDWAIT;
            end
            R_SWR: begin
              w_tmo_next   = 8'd0;
              w_state_next = S_WRWAIT;
            end
            R_STAT: begin
              w_state_next = S_ACK;
            end
            R_LED: begin
              // D0 is only valid once the data strobe is down
              if (!w_ds_s) begin
                w_led_next   = d0_in;
                w_state_next = S_ACK;
              end
            end
            default: begin
              // Interrupt acknowledge: left to _vpa, just wait for _as
              w_state_next = S_HOLD;
            end
          endcase
        end

        S_MEMWAIT: begin
          if (r_cnt == 8'd0) begin
            w_state_next = S_ACK;
          end else begin
            w_cnt_next = r_cnt - 8'd1;
          end
        end

        S_RDWAIT: begin
          if (!w_rdf_s) begin
            w_cnt_next   = c_RD_LOAD;
            w_state_next = S_RDSTB;
          end else if (r_tmo == c_TMO_LAST) begin
            w_state_next = S_BERR;
          end else begin
            w_tmo_next = r_tmo + 8'd1;
          end
        end

        S_WRWAIT: begin
          if (!w_txe_s && !w_ds_s) begin
            w_cnt_next   = c_WR_LOAD;
            w_state_next = S_WRSTB;
          end else if (r_tmo == c_TMO_LAST) begin
            w_state_next = S_BERR;
          end else begin
            w_tmo_next = r_tmo + 8'd1;
          end
        end

        S_RDSTB, S_WRSTB: begin
          if (r_cnt == 8'd0) begin
            w_state_next = S_ACK;
          end else begin
            w_cnt_next = r_cnt - 8'd1;
          end
        end

        S_ACK, S_BERR, S_HOLD: begin
          // Held until _as releases (handled above)
          w_state_next = r_state;
        end

        default: begin
          w_state_next  = S_IDLE;
          w_region_next = R_NONE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs, decoded from the registered state and latched region
  // --------------------------------------------------------------------------
  logic w_active;
  logic w_mem;
  logic w_stat_phase;

  assign w_active     = (r_state != S_IDLE);
  assign w_mem        = (r_region == R_ROM) || (r_region == R_RAM);
  assign w_stat_phase = (r_region == R_STAT) &&
                        ((r_state == S_DECODE) || (r_state == S_ACK));

  assign _cerom = !(w_active && (r_region == R_ROM));
  assign _ceram = !(w_active && (r_region == R_RAM));
  assign _oe    = (w_active && w_mem) ? ~rw : 1'b1;

  // Strobes stay asserted through ACK until _as releases; the two strobes
  // belong to distinct regions so they can never overlap.
  assign _rd = !((r_state == S_RDSTB) ||
                 ((r_state == S_ACK) && (r_region == R_SRD)));
  assign wr  =  (r_state == S_WRSTB) ||
                ((r_state == S_ACK) && (r_region == R_SWR));

  assign _dtack = !(r_state == S_ACK);
  assign _berr  = !(r_state == S_BERR);

  // Status read returns the raw FIFO flag selected by A12
  assign d0_oe      = w_stat_phase;
  assign d0_out     = w_stat_phase && (r_stat_sel ? w_txe_s : w_rdf_s);
  assign status_led = r_status_led;

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_bus_ctrl
//  Brief    : Self-checking bench for cpu_bus_ctrl. Expected timing comes from
//             the cycle latencies of the bus protocol (sync delay, decode,
//             wait states, pulse lengths, timeout) applied to random cycles.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cpu_bus_ctrl;

  localparam int ROM_WS   = 1;
  localparam int RAM_WS   = 0;
  localparam int RD_PULSE = 4;
  localparam int WR_PULSE = 3;
  localparam int TIMEOUT  = 255;

  // _as driven low at falling edge 0 is seen synchronised after rising edge 2
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] addr;
  logic       _as, _ds, rw, fc0, fc1, _txe, _rdf, d0_in;
  logic       _cerom, _ceram, _oe, _rd, wr, _dtack, _berr;
  logic       d0_oe, d0_out, status_led;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_bus_ctrl #(
    .ROM_WS   (ROM_WS),
    .RAM_WS   (RAM_WS),
    .RD_PULSE (RD_PULSE),
    .WR_PULSE (WR_PULSE),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    ._as        (_as),
    ._ds        (_ds),
    .rw         (rw),
    .fc0        (fc0),
    .fc1        (fc1),
    ._txe       (_txe),
    ._rdf       (_rdf),
    .d0_in      (d0_in),
    ._cerom     (_cerom),
    ._ceram     (_ceram),
    ._oe        (_oe),
    ._rd        (_rd),
    .wr         (wr),
    ._dtack     (_dtack),
    ._berr      (_berr),
    .d0_oe      (d0_oe),
    .d0_out     (d0_out),
    .status_led (status_led)
  );

  // Cycle in which the controller acts on a FIFO flag driven at falling edge
  // flag_k: two synchroniser edges, then the decision edge, but never before
  // the wait state has been occupied for one cycle.
  function automatic int strobe_start(input int flag_k);
    int fw;
    fw = flag_k + 3 - (SYNC + 2);
    if (fw < 1) fw = 1;
    return SYNC + 2 + fw;
  endfunction

  // Starts a bus cycle at the next falling edge (edge 0 of the cycle)
  task automatic start_cycle(input logic [7:0] a, input logic r,
                             input logic f1, input logic f0);
    @(negedge clk);
    addr = a; rw = r; fc1 = f1; fc0 = f0;
    _as = 1'b0; _ds = 1'b0;
  endtask

  // Releases the strobes and lets the controller settle back to idle
  task automatic finish_cycle();
    _as = 1'b1; _ds = 1'b1;
    repeat (4) @(negedge clk);
    fc1 = 1'b0; fc0 = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    _as = 1'b0;                       // a strobe during reset must start nothing
    repeat (3) @(negedge clk);
    checks++;
    if ({_cerom, _ceram, _oe, _rd, _dtack, _berr, wr, d0_oe, d0_out, status_led} !== 10'b1111110000) begin
      errors++;
      $display("FAIL reset_outputs got %b exp %b",
               {_cerom, _ceram, _oe, _rd, _dtack, _berr, wr, d0_oe, d0_out, status_led}, 10'b1111110000);
    end
    _as = 1'b1;
    reset = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_rom_ram();
    for (int it = 0; it < 10; it++) begin
      logic [7:0] a;
      logic       r, is_rom;
      logic [5:0] exp_v;
      int         exp_k, got_k;
      if (it == 0) begin
        a = 8'h05; r = 1'b1;
      end else begin
        a = 8'($urandom);
        if (a[7:3] == 5'b01111) a[7] = 1'b1;   // keep off the device window
        r = 1'($urandom);
      end
      is_rom = !a[7];
      exp_k  = SYNC + 2 + (is_rom ? ROM_WS : RAM_WS);
      exp_v  = {~is_rom, is_rom, ~r, 1'b1, 1'b0, 1'b1};
      start_cycle(a, r, 1'b0, 1'b0);
      got_k = -1;
      for (int k = 1; k <= 20 && got_k < 0; k++) begin
        @(negedge clk);
        if (_dtack == 1'b0) got_k = k;
      end
      checks++;
      if (got_k != exp_k) begin
        errors++;
        $display("FAIL mem_latency addr=%h got %0d exp %0d", a, got_k, exp_k);
      end
      checks++;
      if ({_cerom, _ceram, _oe, _rd, wr, _berr} !== exp_v) begin
        errors++;
        $display("FAIL mem_enables addr=%h got %b exp %b", a, {_cerom, _ceram, _oe, _rd, wr, _berr}, exp_v);
      end
      _as = 1'b1; _ds = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (_dtack !== 1'b0) begin
        errors++;
        $display("FAIL mem_hold addr=%h got %b exp 0", a, _dtack);
      end
      @(negedge clk);
      checks++;
      if ({_cerom, _ceram, _oe, _dtack} !== 4'b1111) begin
        errors++;
        $display("FAIL mem_release addr=%h got %b exp 1111", a, {_cerom, _ceram, _oe, _dtack});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_serial_read();
    for (int it = 0; it < 6; it++) begin
      int         flag_k, exp_k, got_k, rd_cycles;
      logic       side_seen;
      logic [7:0] a;
      flag_k = (it == 0) ? 10 : int'($urandom_range(0, 15));
      a      = {5'b01111, 2'b00, 1'($urandom)};
      exp_k  = strobe_start(flag_k) + RD_PULSE;
      _rdf   = 1'b1;
      start_cycle(a, 1'b1, 1'b0, 1'b0);
      if (flag_k == 0) _rdf = 1'b0;
      got_k = -1; rd_cycles = 0; side_seen = 1'b0;
      for (int k = 1; k <= 80 && got_k < 0; k++) begin
        @(negedge clk);
        if (_dtack == 1'b0) got_k = k;
        else if (_rd == 1'b0) rd_cycles++;
        if (_berr == 1'b0 || wr == 1'b1 || _cerom == 1'b0 || _ceram == 1'b0) side_seen = 1'b1;
        if (k == flag_k) _rdf = 1'b0;
      end
      checks++;
      if (got_k != exp_k) begin
        errors++;
        $display("FAIL srd_latency flag_k=%0d got %0d exp %0d", flag_k, got_k, exp_k);
      end
      checks++;
      if (rd_cycles != RD_PULSE || _rd !== 1'b0) begin
        errors++;
        $display("FAIL srd_pulse got %0d cycles rd=%b exp %0d cycles rd=0", rd_cycles, _rd, RD_PULSE);
      end
      checks++;
      if (side_seen !== 1'b0) begin
        errors++;
        $display("FAIL srd_side_outputs got %b exp 0", side_seen);
      end
      _as = 1'b1; _ds = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({_rd, _dtack} !== 2'b11) begin
        errors++;
        $display("FAIL srd_release got %b exp 11", {_rd, _dtack});
      end
      @(negedge clk);
      _rdf = 1'b1;
    end
  endtask

  task automatic test_serial_write();
    int   berr_k;
    logic bad_seen;
    // FIFO never ready: bus error after the timeout, no strobe, no _dtack
    _txe = 1'b1;
    start_cycle(8'h7A, 1'b0, 1'b0, 1'b0);
    berr_k = -1; bad_seen = 1'b0;
    for (int k = 1; k <= 300 && berr_k < 0; k++) begin
      @(negedge clk);
      if (_berr == 1'b0) berr_k = k;
      if (wr == 1'b1 || _dtack == 1'b0) bad_seen = 1'b1;
    end
    checks++;
    if (berr_k != SYNC + 2 + TIMEOUT) begin
      errors++;
      $display("FAIL swr_timeout got %0d exp %0d", berr_k, SYNC + 2 + TIMEOUT);
    end
    repeat (5) begin
      @(negedge clk);
      if (wr == 1'b1 || _dtack == 1'b0 || _berr == 1'b1) bad_seen = 1'b1;
    end
    checks++;
    if (bad_seen !== 1'b0) begin
      errors++;
      $display("FAIL swr_berr_hold got %b exp 0", bad_seen);
    end
    _as = 1'b1; _ds = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (_berr !== 1'b1) begin
      errors++;
      $display("FAIL swr_berr_release got %b exp 1", _berr);
    end
    @(negedge clk);

    // FIFO becomes ready after a random delay
    for (int it = 0; it < 4; it++) begin
      int flag_k, exp_k, got_k, wr_cycles;
      flag_k = int'($urandom_range(0, 15));
      exp_k  = strobe_start(flag_k) + WR_PULSE;
      _txe   = 1'b1;
      start_cycle({5'b01111, 2'b01, 1'($urandom)}, 1'b0, 1'b0, 1'b0);
      if (flag_k == 0) _txe = 1'b0;
      got_k = -1; wr_cycles = 0;
      for (int k = 1; k <= 80 && got_k < 0; k++) begin
        @(negedge clk);
        if (_dtack == 1'b0) got_k = k;
        else if (wr == 1'b1) wr_cycles++;
        if (k == flag_k) _txe = 1'b0;
      end
      checks++;
      if (got_k != exp_k || wr_cycles != WR_PULSE || wr !== 1'b1 || _rd !== 1'b1) begin
        errors++;
        $display("FAIL swr_handshake flag_k=%0d got k=%0d pulse=%0d wr=%b rd=%b exp k=%0d pulse=%0d wr=1 rd=1",
                 flag_k, got_k, wr_cycles, wr, _rd, exp_k, WR_PULSE);
      end
      finish_cycle();
      _txe = 1'b1;
    end
  endtask

  task automatic test_led_status();
    for (int it = 0; it < 4; it++) begin
      logic d;
      int   got_k;
      d = (it == 0 || it == 3) ? 1'b1 : ((it == 1) ? 1'b0 : 1'($urandom));
      d0_in = d;
      start_cycle({7'b0111_111, 1'($urandom)}, 1'b0, 1'b0, 1'b0);
      got_k = -1;
      for (int k = 1; k <= 20 && got_k < 0; k++) begin
        @(negedge clk);
        if (_dtack == 1'b0) got_k = k;
      end
      checks++;
      if (got_k != SYNC + 2 || status_led !== d || _oe !== 1'b1) begin
        errors++;
        $display("FAIL led_write got k=%0d led=%b oe=%b exp k=%0d led=%b oe=1", got_k, status_led, _oe, SYNC + 2, d);
      end
      finish_cycle();
    end
    for (int it = 0; it < 5; it++) begin
      logic sel, txe_v, rdf_v, exp_d;
      int   got_k;
      if (it == 0) begin
        sel = 1'b1; txe_v = 1'b0; rdf_v = 1'b1;
      end else begin
        sel = 1'($urandom); txe_v = 1'($urandom); rdf_v = 1'($urandom);
      end
      exp_d = sel ? txe_v : rdf_v;
      _txe = txe_v; _rdf = rdf_v;
      start_cycle({7'b0111_110, sel}, 1'b1, 1'b0, 1'b0);
      got_k = -1;
      for (int k = 1; k <= 20 && got_k < 0; k++) begin
        @(negedge clk);
        if (_dtack == 1'b0) got_k = k;
      end
      checks++;
      if (got_k != SYNC + 2 || d0_oe !== 1'b1 || d0_out !== exp_d || _oe !== 1'b1) begin
        errors++;
        $display("FAIL status_read sel=%b got k=%0d oe=%b d0=%b moe=%b exp k=%0d oe=1 d0=%b moe=1",
                 sel, got_k, d0_oe, d0_out, _oe, SYNC + 2, exp_d);
      end
      finish_cycle();
      checks++;
      if ({d0_oe, d0_out} !== 2'b00) begin
        errors++;
        $display("FAIL status_release got %b exp 00", {d0_oe, d0_out});
      end
    end
    _txe = 1'b1; _rdf = 1'b1;
  endtask

  task automatic test_iack();
    for (int it = 0; it < 3; it++) begin
      logic bad_seen;
      logic [7:0] a;
      a = (it == 0) ? 8'h7E : 8'($urandom);
      start_cycle(a, 1'b1, 1'b1, 1'b1);
      bad_seen = 1'b0;
      repeat (20) begin
        @(negedge clk);
        if ({_cerom, _ceram, _oe, _rd, _dtack, _berr, wr, d0_oe} !== 8'b11111100) bad_seen = 1'b1;
      end
      checks++;
      if (bad_seen !== 1'b0) begin
        errors++;
        $display("FAIL iack_quiet addr=%h got %b exp 0", a, bad_seen);
      end
      finish_cycle();
    end
  endtask

  task automatic test_reset_mid_strobe();
    int got_k;
    _rdf = 1'b0;
    start_cycle(8'h78, 1'b1, 1'b0, 1'b0);
    repeat (SYNC + 4) @(negedge clk);          // inside the read pulse
    checks++;
    if (_rd !== 1'b0) begin
      errors++;
      $display("FAIL rst_pre_strobe got %b exp 0", _rd);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({_rd, _dtack, _cerom, _ceram, _oe, _berr, wr, d0_oe, status_led} !== 9'b111111000) begin
      errors++;
      $display("FAIL rst_async got %b exp 111111000", {_rd, _dtack, _cerom, _ceram, _oe, _berr, wr, d0_oe, status_led});
    end
    _as = 1'b1; _ds = 1'b1; _rdf = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    // A fresh ROM cycle must decode with full latency from idle
    start_cycle(8'h10, 1'b1, 1'b0, 1'b0);
    got_k = -1;
    for (int k = 1; k <= 20 && got_k < 0; k++) begin
      @(negedge clk);
      if (_dtack == 1'b0) got_k = k;
    end
    checks++;
    if (got_k != SYNC + 2 + ROM_WS || _cerom !== 1'b0) begin
      errors++;
      $display("FAIL rst_recover got k=%0d ce=%b exp k=%0d ce=0", got_k, _cerom, SYNC + 2 + ROM_WS);
    end
    finish_cycle();
  endtask

  task automatic test_abort_write();
    logic       bad_seen;
    logic [7:0] a;
    logic       r;
    int         got_k;
    _txe = 1'b1;
    start_cycle(8'h7A, 1'b0, 1'b0, 1'b0);
    bad_seen = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (wr == 1'b1 || _dtack == 1'b0 || _berr == 1'b0) bad_seen = 1'b1;
      if (k == 8) begin
        _as = 1'b1; _ds = 1'b1;
      end
      if (k == 12) _txe = 1'b0;                 // FIFO ready after the abort
    end
    checks++;
    if (bad_seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_strobe got %b exp 0", bad_seen);
    end
    a = {1'b1, 7'($urandom)};
    r = 1'($urandom);
    start_cycle(a, r, 1'b0, 1'b0);
    got_k = -1;
    for (int k = 1; k <= 20 && got_k < 0; k++) begin
      @(negedge clk);
      if (_dtack == 1'b0) got_k = k;
    end
    checks++;
    if (got_k != SYNC + 2 + RAM_WS || _ceram !== 1'b0 || _cerom !== 1'b1 || _oe !== ~r || wr !== 1'b0) begin
      errors++;
      $display("FAIL abort_next_cycle addr=%h got k=%0d ceram=%b cerom=%b oe=%b wr=%b exp k=%0d 0 1 %b 0",
               a, got_k, _ceram, _cerom, _oe, wr, SYNC + 2 + RAM_WS, ~r);
    end
    finish_cycle();
    _txe = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    addr  = 8'h00;
    _as   = 1'b1; _ds = 1'b1; rw = 1'b1;
    fc0   = 1'b0; fc1 = 1'b0;
    _txe  = 1'b1; _rdf = 1'b1;
    d0_in = 1'b0;
    test_reset();
    test_rom_ram();
    test_serial_read();
    test_serial_write();
    test_led_status();
    test_iack();
    test_reset_mid_strobe();
    test_abort_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
